// File: rtl/gf22_sram_pkg.sv
// Shared types and helpers for the banked byte/bit-masked SRAM wrapper.
// GF22_SRAM_OUTREG_EN selects the registered-output read latency.
package gf22_sram_pkg;

  // Upper bounds on the configurable widths; the buffer entry is sized to these.
  localparam int WB_AW_MAX = 32;
  localparam int WB_DW_MAX = 128;

`ifdef GF22_SRAM_OUTREG_EN
  localparam int RD_LAT = 2;
`else
  localparam int RD_LAT = 1;
`endif

  typedef struct packed {
    logic                 valid;
    logic [WB_AW_MAX-1:0] addr;
    logic [WB_DW_MAX-1:0] data;
    logic [WB_DW_MAX-1:0] mask;
  } wb_ent_t;

  function automatic logic [WB_AW_MAX-1:0] bank_of(input logic [WB_AW_MAX-1:0] a,
                                                   input int addr_w, input int bank_aw);
    logic [WB_AW_MAX-1:0] msk;
    msk = (WB_AW_MAX'(1) << (addr_w - bank_aw)) - WB_AW_MAX'(1);
    return (a >> bank_aw) & msk;
  endfunction

endpackage

// File: rtl/gf22_sram_sp.sv
// Behavioural single-port bit-masked SRAM macro; read data is registered
// and held between reads.
module gf22_sram_sp #(
  parameter int DATA_W = 32,
  parameter int AW     = 13
) (
  input  logic              clk,
  input  logic              ce,
  input  logic              we,
  input  logic [AW-1:0]     a,
  input  logic [DATA_W-1:0] d,
  input  logic [DATA_W-1:0] bm,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (ce) begin
      if (we) mem[a] <= (mem[a] & ~bm) | (d & bm);
      else    q      <= mem[a];
    end
  end

endmodule

// File: rtl/gf22_sram_wbuf.sv
// One-entry write buffer: accept/park/drain decisions, forward hit and merge.
// GF22_SRAM_OUTREG_EN adds a register stage after the merge (QV1 resets to 0).
module gf22_sram_wbuf import gf22_sram_pkg::*; #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 17,
  parameter int BANK_AW = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] a0,
  input  logic [DATA_W-1:0] d0,
  input  logic [DATA_W-1:0] m0,
  output logic              rdy0,
  input  logic              ce1,
  input  logic [ADDR_W-1:0] a1,
  output logic              wr_v,
  output logic [ADDR_W-1:0] wr_a,
  output logic [DATA_W-1:0] wr_d,
  output logic [DATA_W-1:0] wr_m,
  input  logic [DATA_W-1:0] macro_q,
  output logic [DATA_W-1:0] q1,
  output logic              qv1
);

  wb_ent_t              wb;
  logic [WB_AW_MAX-1:0] a0_x, a1_x;
  logic                 rd_on_wb, same_rw, acc, capture, drain, hit;
  logic                 rd_r;
  logic [DATA_W-1:0]    fwd_d, fwd_m, merged;

  assign a0_x = WB_AW_MAX'(a0);
  assign a1_x = WB_AW_MAX'(a1);

  assign rd_on_wb = ce1 && (bank_of(a1_x, ADDR_W, BANK_AW) == bank_of(wb.addr, ADDR_W, BANK_AW));
  assign same_rw  = ce1 && (bank_of(a0_x, ADDR_W, BANK_AW) == bank_of(a1_x, ADDR_W, BANK_AW));

  // Nothing reaches a macro during reset, so a parked write is really discarded.
  assign acc     = ce0 && we0 && !wb.valid && !rst;
  assign capture = acc && same_rw;
  assign drain   = wb.valid && !rd_on_wb && !rst;
  assign hit     = ce1 && wb.valid && (wb.addr == a1_x);
  assign rdy0    = !wb.valid;

  assign wr_v = drain || (acc && !capture);
  assign wr_a = drain ? ADDR_W'(wb.addr) : a0;
  assign wr_d = drain ? DATA_W'(wb.data) : d0;
  assign wr_m = drain ? DATA_W'(wb.mask) : m0;

  always_ff @(posedge clk) begin
    if (rst)          wb.valid <= 1'b0;
    else if (capture) wb <= '{valid: 1'b1, addr: a0_x,
                              data: WB_DW_MAX'(d0), mask: WB_DW_MAX'(m0)};
    else if (drain)   wb.valid <= 1'b0;
  end

  // Forward copy is frozen at read issue; a zero mask means "macro data only".
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_r  <= 1'b0;
      fwd_d <= '0;
      fwd_m <= '0;
    end else begin
      rd_r <= ce1;
      if (ce1) begin
        fwd_d <= DATA_W'(wb.data);
        fwd_m <= hit ? DATA_W'(wb.mask) : '0;
      end
    end
  end

  assign merged = (macro_q & ~fwd_m) | (fwd_d & fwd_m);

`ifdef GF22_SRAM_OUTREG_EN
  always_ff @(posedge clk) begin
    if (rst) qv1 <= 1'b0;
    else     qv1 <= rd_r;
    q1 <= merged;
  end
`else
  assign q1  = merged;
  assign qv1 = rd_r;
`endif

  if (DATA_W < WB_DW_MAX) begin : g_hi
    logic unused_wb_hi;
    assign unused_wb_hi = ^{wb.data[WB_DW_MAX-1:DATA_W], wb.mask[WB_DW_MAX-1:DATA_W]};
  end

endmodule

// File: rtl/gf22_sram_be_banked_wb.sv
// 1W/1R bit-masked memory over 2^(ADDR_W-BANK_AW) single-port macros with a
// parked-write buffer for same-bank collisions.
module gf22_sram_be_banked_wb import gf22_sram_pkg::*; #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 17,
  parameter int BANK_AW = 13
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CE0,
  input  logic [ADDR_W-1:0] A0,
  input  logic [DATA_W-1:0] D0,
  input  logic              WE0,
  input  logic [DATA_W-1:0] WEM0,
  output logic              RDY0,
  input  logic              CE1,
  input  logic [ADDR_W-1:0] A1,
  output logic [DATA_W-1:0] Q1,
  output logic              QV1
);

  localparam int BW     = ADDR_W - BANK_AW;
  localparam int NBANKS = 1 << BW;

  logic                           wr_v;
  logic [ADDR_W-1:0]              wr_a;
  logic [DATA_W-1:0]              wr_d, wr_m, macro_q;
  logic [BW-1:0]                  rd_bank, wr_bank, bank_r;
  logic [NBANKS-1:0][DATA_W-1:0]  bank_q;

  assign rd_bank = BW'(bank_of(WB_AW_MAX'(A1), ADDR_W, BANK_AW));
  assign wr_bank = BW'(bank_of(WB_AW_MAX'(wr_a), ADDR_W, BANK_AW));

  always_ff @(posedge CLK) begin
    if (RST)      bank_r <= '0;
    else if (CE1) bank_r <= rd_bank;
  end

  assign macro_q = bank_q[bank_r];

  gf22_sram_wbuf #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BANK_AW(BANK_AW)) u_wbuf (
    .clk(CLK), .rst(RST),
    .ce0(CE0), .we0(WE0), .a0(A0), .d0(D0), .m0(WEM0), .rdy0(RDY0),
    .ce1(CE1), .a1(A1),
    .wr_v(wr_v), .wr_a(wr_a), .wr_d(wr_d), .wr_m(wr_m),
    .macro_q(macro_q), .q1(Q1), .qv1(QV1)
  );

  // The wbuf guarantees a write never targets the bank the read owns.
  for (genvar b = 0; b < NBANKS; b++) begin : g_bank
    logic rd_sel, wr_sel;
    assign rd_sel = CE1  && (rd_bank == BW'(b));
    assign wr_sel = wr_v && (wr_bank == BW'(b));

    gf22_sram_sp #(.DATA_W(DATA_W), .AW(BANK_AW)) u_macro (
      .clk(CLK),
      .ce (rd_sel || wr_sel),
      .we (wr_sel),
      .a  (wr_sel ? wr_a[BANK_AW-1:0] : A1[BANK_AW-1:0]),
      .d  (wr_d),
      .bm (wr_m),
      .q  (bank_q[b])
    );
  end

endmodule

// File: tb/tb_gf22_sram_be_banked_wb.sv
// Randomised + directed bench with a coherent-memory reference model.
module tb_gf22_sram_be_banked_wb;

  localparam int DW  = 32;
  localparam int AW  = 17;
  localparam int BAW = 13;
`ifdef GF22_SRAM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          CLK = 1'b0, RST = 1'b1;
  logic          CE0 = 1'b0, WE0 = 1'b0, CE1 = 1'b0;
  logic [AW-1:0] A0 = '0, A1 = '0;
  logic [DW-1:0] D0 = '0, WEM0 = '0;
  logic          RDY0, QV1;
  logic [DW-1:0] Q1;

  always #5 CLK = ~CLK;

  gf22_sram_be_banked_wb #(.DATA_W(DW), .ADDR_W(AW), .BANK_AW(BAW)) dut (
    .CLK(CLK), .RST(RST), .CE0(CE0), .A0(A0), .D0(D0), .WE0(WE0), .WEM0(WEM0),
    .RDY0(RDY0), .CE1(CE1), .A1(A1), .Q1(Q1), .QV1(QV1)
  );

  int n_cmp = 0, n_bad = 0;
  bit started = 1'b0;

  // literal expectation attached to the read being issued this cycle
  bit          cur_lit_has = 1'b0;
  logic [31:0] cur_lit = '0;
  string       cur_lit_nm = "";

  // ---- reference model: architectural memory + one parked write ----
  logic [31:0] mem [int];
  bit          pend_v = 1'b0;
  int          pend_a = 0;
  logic [31:0] pend_d = '0, pend_m = '0;
  bit          ev [1:2] = '{1'b0, 1'b0};
  logic [31:0] ed [1:2];
  bit          el [1:2] = '{1'b0, 1'b0};
  logic [31:0] elv [1:2];
  string       en [1:2];

  function automatic int bank(input int a);
    return a >> BAW;
  endfunction

  function automatic logic [31:0] view(input int a);
    logic [31:0] v;
    v = mem.exists(a) ? mem[a] : 'x;
    if (pend_v && pend_a == a) v = (v & ~pend_m) | (pend_d & pend_m);
    return v;
  endfunction

  task automatic commit(input int a, input logic [31:0] d, input logic [31:0] m);
    logic [31:0] old;
    old = mem.exists(a) ? mem[a] : 'x;
    mem[a] = (old & ~m) | (d & m);
  endtask

  initial begin : model
    bit drain, acc;
    forever begin
      @(posedge CLK);
      if (RST) begin
        pend_v = 1'b0;
        ev[1] = 1'b0; ev[2] = 1'b0;
      end else begin
        ev[2] = ev[1]; ed[2] = ed[1]; el[2] = el[1]; elv[2] = elv[1]; en[2] = en[1];
        ev[1] = CE1; ed[1] = view(int'(A1));
        el[1] = CE1 && cur_lit_has; elv[1] = cur_lit; en[1] = cur_lit_nm;
        drain = pend_v && !(CE1 && bank(int'(A1)) == bank(pend_a));
        acc   = CE0 && WE0 && !pend_v;
        if (drain) begin
          commit(pend_a, pend_d, pend_m);
          pend_v = 1'b0;
        end
        if (acc) begin
          if (CE1 && bank(int'(A0)) == bank(int'(A1))) begin
            pend_v = 1'b1; pend_a = int'(A0); pend_d = D0; pend_m = WEM0;
          end else begin
            commit(int'(A0), D0, WEM0);
          end
        end
      end
    end
  end

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---- per-cycle compare against the model ----
  initial begin : compare
    forever begin
      @(negedge CLK);
      if (started) begin
        chk1("rdy0", RDY0, !pend_v);
        chk1("qv1", QV1, ev[LAT]);
        if (ev[LAT] && !$isunknown(ed[LAT])) chk32("q1", Q1, ed[LAT]);
        if (ev[LAT] && el[LAT]) chk32(en[LAT], Q1, elv[LAT]);
      end
    end
  end

  // one cycle of stimulus, driven on the falling edge
  task automatic step(input bit ce0, input bit we0, input int a0, input logic [31:0] d0,
                      input logic [31:0] m0, input bit ce1, input int a1,
                      input bit lit = 1'b0, input logic [31:0] lv = '0, input string nm = "");
    CE0 = ce0; WE0 = we0; A0 = AW'(a0); D0 = d0; WEM0 = m0;
    CE1 = ce1; A1 = AW'(a1);
    cur_lit_has = lit; cur_lit = lv; cur_lit_nm = nm;
    @(negedge CLK);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 0, '0, '0, 1'b0, 0);
  endtask

  int pool [12] = '{32'h00000, 32'h00001, 32'h00002, 32'h00003, 32'h00007, 32'h00010,
                    32'h02001, 32'h02005, 32'h02100, 32'h04000, 32'h04003, 32'h1F000};
  int b0 [6] = '{32'h00000, 32'h00001, 32'h00002, 32'h00003, 32'h00007, 32'h00010};

  initial begin : drive
    int a;
    logic [31:0] m;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    started = 1'b1;
    chk1("reset_rdy0", RDY0, 1'b1);
    chk1("reset_qv1", QV1, 1'b0);

    // preload the address pool
    foreach (pool[i])
      step(1'b1, 1'b1, pool[i], (pool[i] == 32'h7) ? 32'h1111_1111 : $urandom, '1, 1'b0, 0);

    // direct write then read next cycle
    step(1'b1, 1'b1, 32'h10, 32'h0000_1234, '1, 1'b0, 0);
    step(1'b0, 1'b0, 0, '0, '0, 1'b1, 32'h10, 1'b1, 32'h0000_1234, "s1_read");
    chk1("s1_qv_cyc1", QV1, LAT == 1);
    idle();
    chk1("s1_qv_cyc2", QV1, LAT == 2);
    idle();

    // same-bank collision parks the write; a read elsewhere drains it
    step(1'b1, 1'b1, 32'h02005, 32'hAAAA_AAAA, '1, 1'b1, 32'h02001);
    chk1("s2_rdy_low", RDY0, 1'b0);
    step(1'b0, 1'b0, 0, '0, '0, 1'b1, 32'h04000);
    chk1("s2_rdy_high", RDY0, 1'b1);
    step(1'b0, 1'b0, 0, '0, '0, 1'b1, 32'h02005, 1'b1, 32'hAAAA_AAAA, "s2_drained");
    idle(); idle();

    // read-before-write, then forwarding of the masked write
    step(1'b1, 1'b1, 32'h7, 32'hFFFF_FFFF, 32'h0000_FFFF, 1'b1, 32'h7, 1'b1, 32'h1111_1111, "s3_rbw");
    step(1'b0, 1'b0, 0, '0, '0, 1'b1, 32'h7, 1'b1, 32'h1111_FFFF, "s3_fwd");
    idle(); idle();

    // starvation: 16 reads of bank 0 while a bank-0 write is parked
    step(1'b1, 1'b1, 32'h3, 32'h5A5A_5A5A, '1, 1'b1, 32'h2);
    chk1("s4_rdy_low", RDY0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      a = b0[i % 6];
      step(1'b1, 1'b1, 32'h3, 32'hDEAD_BEEF, '1, 1'b1, a, a == 32'h3, 32'h5A5A_5A5A, "s4_fwd");
      chk1("s4_starve", RDY0, 1'b0);
    end
    idle();
    chk1("s4_drain_rdy", RDY0, 1'b1);
    step(1'b0, 1'b0, 0, '0, '0, 1'b1, 32'h3, 1'b1, 32'h5A5A_5A5A, "s4_after");
    idle(); idle();

    // reset discards a parked write
    step(1'b1, 1'b1, 32'h02005, 32'h1234_5678, '1, 1'b1, 32'h02001);
    chk1("s5_rdy_low", RDY0, 1'b0);
    RST = 1'b1;
    idle();
    RST = 1'b0;
    chk1("s5_rdy", RDY0, 1'b1);
    chk1("s5_qv", QV1, 1'b0);
    step(1'b0, 1'b0, 0, '0, '0, 1'b1, 32'h02005, 1'b1, 32'hAAAA_AAAA, "s5_discard");
    idle(); idle();

    // random traffic over a collision-heavy pool
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        RST = 1'b1;
        idle();
        RST = 1'b0;
      end else begin
        case ($urandom_range(0, 2))
          0:       m = '1;
          1:       m = 32'hFFFF_0000;
          default: m = $urandom;
        endcase
        step($urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
             pool[$urandom_range(0, 11)], $urandom, m,
             $urandom_range(0, 2) != 0, pool[$urandom_range(0, 11)]);
      end
    end
    repeat (4) idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
